// File: rtl/hdc_pkg.sv
// Shared HDC definitions: slice-sequencer state encoding and a vector slice helper.
package hdc_pkg;

    localparam int unsigned NUM_HVS_DEF  = 6;
    localparam int unsigned DIM_DEF      = 64;
    localparam int unsigned PAR_BITS_DEF = 2;

    // Widest vector / slice the helper accepts; callers zero-extend and truncate.
    localparam int unsigned VEC_MAX   = 1024;
    localparam int unsigned SLICE_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } bss_state_t;

    // Slice k of vec, where each slice is `width` bits, right-aligned in the result.
    function automatic logic [SLICE_MAX-1:0] slice_of(
        input logic [VEC_MAX-1:0] vec,
        input int unsigned        k,
        input int unsigned        width
    );
        logic [VEC_MAX-1:0] shifted;
        shifted = vec >> (k * width);
        return shifted[SLICE_MAX-1:0];
    endfunction

endpackage

// File: rtl/bundler_slice_sequencer.sv
// Streams NUM_HVS hypervectors plus two tie vectors to bundler_bits one
// PAR_BITS slice at a time and reassembles the returned slices into out_hv.
module bundler_slice_sequencer
    import hdc_pkg::*;
#(
    parameter int unsigned NUM_HVS  = NUM_HVS_DEF,
    parameter int unsigned DIM      = DIM_DEF,
    parameter int unsigned PAR_BITS = PAR_BITS_DEF
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start,
    input  logic [NUM_HVS-1:0][DIM-1:0]        hvs,
    input  logic [DIM-1:0]                     ties_1_hv,
    input  logic [DIM-1:0]                     ties_2_hv,
    output logic                               busy,
    output logic                               done,
    output logic [DIM-1:0]                     out_hv,
    output logic                               bund_en,
    output logic [NUM_HVS-1:0][PAR_BITS-1:0]   bund_bits,
    output logic [PAR_BITS-1:0]                bund_ties_1,
    output logic [PAR_BITS-1:0]                bund_ties_2,
    input  logic                               bund_done,
    input  logic [PAR_BITS-1:0]                bund_out
);

    localparam int unsigned NUM_SLICES = DIM / PAR_BITS;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    bss_state_t                       state, state_d;
    logic [IDX_W-1:0]                 idx, idx_d;
    logic [IDX_W-1:0]                 slice_sel;
    logic                             busy_d, done_d, bund_en_d;
    logic [DIM-1:0]                   out_hv_d;
    logic [NUM_HVS-1:0][PAR_BITS-1:0] bund_bits_d, slice_bits;
    logic [PAR_BITS-1:0]              bund_ties_1_d, bund_ties_2_d;
    logic [PAR_BITS-1:0]              slice_t1, slice_t2;

    // Slice that would be loaded on the next issue: 0 from IDLE, else idx+1.
    assign slice_sel = (state == IDLE) ? '0 : idx + IDX_W'(1);

    always_comb begin
        for (int unsigned i = 0; i < NUM_HVS; i++) begin
            slice_bits[i] = PAR_BITS'(slice_of(VEC_MAX'(hvs[i]), 32'(slice_sel), PAR_BITS));
        end
        slice_t1 = PAR_BITS'(slice_of(VEC_MAX'(ties_1_hv), 32'(slice_sel), PAR_BITS));
        slice_t2 = PAR_BITS'(slice_of(VEC_MAX'(ties_2_hv), 32'(slice_sel), PAR_BITS));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        busy_d        = busy;
        done_d        = 1'b0;
        bund_en_d     = 1'b0;
        out_hv_d      = out_hv;
        bund_bits_d   = bund_bits;
        bund_ties_1_d = bund_ties_1;
        bund_ties_2_d = bund_ties_2;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d       = ISSUE;
                    idx_d         = '0;
                    busy_d        = 1'b1;
                    bund_en_d     = 1'b1;
                    bund_bits_d   = slice_bits;
                    bund_ties_1_d = slice_t1;
                    bund_ties_2_d = slice_t2;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bund_done) begin
                    out_hv_d[idx*PAR_BITS +: PAR_BITS] = bund_out;
                    if (idx == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        idx_d         = idx + IDX_W'(1);
                        bund_en_d     = 1'b1;
                        bund_bits_d   = slice_bits;
                        bund_ties_1_d = slice_t1;
                        bund_ties_2_d = slice_t2;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bund_en     <= 1'b0;
            out_hv      <= '0;
            bund_bits   <= '0;
            bund_ties_1 <= '0;
            bund_ties_2 <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            busy        <= busy_d;
            done        <= done_d;
            bund_en     <= bund_en_d;
            out_hv      <= out_hv_d;
            bund_bits   <= bund_bits_d;
            bund_ties_1 <= bund_ties_1_d;
            bund_ties_2 <= bund_ties_2_d;
        end
    end

endmodule

// File: tb/tb_bundler_slice_sequencer.sv
// Scoreboard bench for bundler_slice_sequencer with a latency-programmable bundler stub.
`timescale 1ns/1ps
module tb_bundler_slice_sequencer;

    localparam int NH = 6;
    localparam int D  = 8;
    localparam int P  = 2;
    localparam int NS = D / P;

    logic                     clk = 1'b0;
    logic                     nrst, start;
    logic [NH-1:0][D-1:0]     hvs;
    logic [D-1:0]             ties_1_hv, ties_2_hv;
    logic                     busy, done;
    logic [D-1:0]             out_hv;
    logic                     bund_en;
    logic [NH-1:0][P-1:0]     bund_bits;
    logic [P-1:0]             bund_ties_1, bund_ties_2;
    logic                     bund_done;
    logic [P-1:0]             bund_out;

    always #5 clk = ~clk;

    bundler_slice_sequencer #(.NUM_HVS(NH), .DIM(D), .PAR_BITS(P)) dut (
        .clk(clk), .nrst(nrst), .start(start), .hvs(hvs),
        .ties_1_hv(ties_1_hv), .ties_2_hv(ties_2_hv),
        .busy(busy), .done(done), .out_hv(out_hv),
        .bund_en(bund_en), .bund_bits(bund_bits),
        .bund_ties_1(bund_ties_1), .bund_ties_2(bund_ties_2),
        .bund_done(bund_done), .bund_out(bund_out)
    );

    typedef struct {
        logic [NH-1:0][P-1:0] bits;
        logic [P-1:0]         t1;
        logic [P-1:0]         t2;
        int                   cyc;
    } slice_exp_t;

    typedef struct {
        logic [D-1:0] hv;
        int           cyc;
    } done_exp_t;

    slice_exp_t slice_q[$];
    done_exp_t  done_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_count = 0;
    int lat[NS];
    int stub_mode = 0;
    bit stray_on_en = 1'b0;
    bit stray_idle = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result over whole vectors: mode 0 echoes hvs[0]; mode 1 is a
    // per-bit majority with exact ties taken from ties_1_hv.
    function automatic logic [D-1:0] model_out(input logic [NH-1:0][D-1:0] v,
                                               input logic [D-1:0] t1, input int mode);
        logic [D-1:0] r;
        int ones;
        for (int j = 0; j < D; j++) begin
            ones = 0;
            for (int i = 0; i < NH; i++) ones += int'(v[i][j]);
            if (mode == 0)          r[j] = v[0][j];
            else if (2 * ones > NH) r[j] = 1'b1;
            else if (2 * ones < NH) r[j] = 1'b0;
            else                    r[j] = t1[j];
        end
        return r;
    endfunction

    // Stub bundler operating on whatever slice the DUT presents.
    function automatic logic [P-1:0] stub_fn(input logic [NH-1:0][P-1:0] b,
                                             input logic [P-1:0] t1, input int mode);
        logic [P-1:0] r;
        int ones;
        for (int j = 0; j < P; j++) begin
            ones = 0;
            for (int i = 0; i < NH; i++) ones += int'(b[i][j]);
            if (mode == 0)          r[j] = b[0][j];
            else if (2 * ones > NH) r[j] = 1'b1;
            else if (2 * ones < NH) r[j] = 1'b0;
            else                    r[j] = t1[j];
        end
        return r;
    endfunction

    // Bundler stub: done L cycles after each en, random data whenever not done.
    initial begin
        int target;
        int en_cnt;
        logic [P-1:0] res;
        target = -1;
        en_cnt = 0;
        res = '0;
        bund_done = 1'b0;
        bund_out = '0;
        forever begin
            @(negedge clk);
            if (!busy) en_cnt = 0;
            bund_done = 1'b0;
            bund_out = P'($urandom);
            if (bund_en) begin
                target = cyc + lat[en_cnt % NS];
                en_cnt++;
                res = stub_fn(bund_bits, bund_ties_1, stub_mode);
                if (stray_on_en) bund_done = 1'b1;
            end
            if (cyc == target) begin
                bund_done = 1'b1;
                bund_out = res;
            end else if (stray_idle && !busy) begin
                bund_done = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a slice or signals done.
    initial begin
        bit chk_busy_low;
        slice_exp_t s;
        done_exp_t e;
        chk_busy_low = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_busy_low) begin
                check("busy_after_done", 64'(busy), 64'(0));
                chk_busy_low = 1'b0;
            end
            if (bund_en) begin
                if (slice_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en: got bund_en=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    s = slice_q.pop_front();
                    check("slice_bits", 64'(bund_bits), 64'(s.bits));
                    check("slice_ties_1", 64'(bund_ties_1), 64'(s.t1));
                    check("slice_ties_2", 64'(bund_ties_2), 64'(s.t2));
                    check("en_cycle", 64'(cyc), 64'(s.cyc));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = done_q.pop_front();
                    check("out_hv", 64'(out_hv), 64'(e.hv));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_at_done", 64'(busy), 64'(1));
                    chk_busy_low = 1'b1;
                end
                done_count++;
            end
        end
    end

    task automatic launch(input int mode);
        int start_cyc;
        int rel;
        done_exp_t e;
        @(negedge clk);
        stub_mode = mode;
        start = 1'b1;
        start_cyc = cyc + 1;
        rel = 1;
        for (int k = 0; k < NS; k++) begin
            slice_exp_t s;
            for (int i = 0; i < NH; i++) s.bits[i] = P'((hvs[i] >> (k * P)) % (1 << P));
            s.t1 = P'((ties_1_hv >> (k * P)) % (1 << P));
            s.t2 = P'((ties_2_hv >> (k * P)) % (1 << P));
            s.cyc = start_cyc + rel - 1;
            slice_q.push_back(s);
            rel += lat[k] + 1;
        end
        e.hv = model_out(hvs, ties_1_hv, mode);
        e.cyc = start_cyc + rel - 1;
        done_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int goal;
        int n;
        goal = done_count + 1;
        n = 0;
        while (done_count < goal && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count < goal) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
        end
        @(negedge clk);
        check("slices_left", 64'(slice_q.size()), 64'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_bund_en"}, 64'(bund_en), 64'(0));
        check({tag, "_out_hv"}, 64'(out_hv), 64'(0));
        check({tag, "_bund_bits"}, 64'(bund_bits), 64'(0));
        check({tag, "_ties_1"}, 64'(bund_ties_1), 64'(0));
        check({tag, "_ties_2"}, 64'(bund_ties_2), 64'(0));
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NH; i++) hvs[i] = D'($urandom);
        ties_1_hv = D'($urandom);
        ties_2_hv = D'($urandom);
    endtask

    initial begin
        int n;
        logic [D-1:0] held;
        nrst = 1'b0;
        start = 1'b0;
        hvs = '0;
        ties_1_hv = '0;
        ties_2_hv = '0;
        for (int k = 0; k < NS; k++) lat[k] = 1;

        // Reset and idle.
        repeat (5) @(negedge clk);
        check_reset_vals("rst");
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("idle");

        // Echo stub, L=1: slices 00,01,11,10 and done at cycle 9.
        randomize_inputs();
        hvs[0] = 8'hB4;
        launch(0);
        wait_done(200);
        check("echo_b4", 64'(out_hv), 64'h00B4);

        // Majority with ignored start and done coincident with every en.
        for (int i = 0; i < NH; i++) hvs[i] = (i < 4) ? 8'hF0 : 8'h0F;
        ties_1_hv = '0;
        ties_2_hv = '0;
        stray_on_en = 1'b1;
        launch(1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        stray_on_en = 1'b0;
        check("majority_f0", 64'(out_hv), 64'h00F0);

        // Stray done while idle must not touch out_hv.
        held = out_hv;
        n = done_count;
        stray_idle = 1'b1;
        repeat (5) @(negedge clk);
        stray_idle = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_stray_out_hv", 64'(out_hv), 64'(held));
        check("idle_stray_no_done", 64'(done_count), 64'(n));
        check("idle_stray_busy", 64'(busy), 64'(0));

        // Reset during slice 2 WAIT, with the stub's done arriving afterwards.
        randomize_inputs();
        lat[0] = 1; lat[1] = 1; lat[2] = 4; lat[3] = 1;
        launch(1);
        n = 0;
        while (slice_q.size() > 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_slice2", 64'(slice_q.size()), 64'(1));
        @(negedge clk);
        nrst = 1'b0;
        slice_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        check_reset_vals("midrst");
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("postrst");
        for (int k = 0; k < NS; k++) lat[k] = 2;
        randomize_inputs();
        launch(1);
        wait_done(200);

        // Variable latency 1,3,2,5: done at cycle 16.
        randomize_inputs();
        lat[0] = 1; lat[1] = 3; lat[2] = 2; lat[3] = 5;
        launch(0);
        wait_done(200);

        // Randomized operations.
        for (int t = 0; t < 10; t++) begin
            randomize_inputs();
            for (int k = 0; k < NS; k++) lat[k] = int'($urandom_range(1, 5));
            launch(int'($urandom_range(0, 1)));
            wait_done(300);
        end

        repeat (4) @(negedge clk);
        check("final_slice_q", 64'(slice_q.size()), 64'(0));
        check("final_done_q", 64'(done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
